vector_stream_memory: RTL and testbench

Parametrised multi-vector operand store for the dot-product datapath. Elements are written one at a time over a valid/ready port and tracked per vector by a "loaded" bitmap. On request, a whole vector is streamed out one element per cycle over a valid/ready port with last-flag and backpressure. It sits between the operand loader and the MAC array.

---
 rtl/vector_stream_memory.sv | 171 +++++++++++++++++
 tb/tb_vector_stream_memory.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_stream_memory.sv
// vector_stream_memory: multi-vector operand store for the dot-product datapath.
// Elements are written one at a time. A per-vector "loaded" bitmap tracks which
// vectors are complete. On request, a whole vector streams out one element per
// cycle, with a last flag and downstream backpressure.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_valid/wr_ready               element write handshake
//   wr_vec, wr_elem                 write target (vector, element); out-of-range writes are dropped
//   wr_data, wr_last                element value; wr_last marks the vector complete
//   rd_req_valid/rd_req_ready       stream request handshake
//   rd_req_vec                      vector to stream
//   rd_err                          one-cycle pulse when an unloaded/out-of-range vector is requested
//   out_valid/out_ready             stream element handshake
//   out_data, out_elem, out_last    element value, its index, last-element flag
//   vec_loaded                      per-vector completion bitmap
module vector_stream_memory #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned VEC_LEN     = 8,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned VEC_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    parameter int unsigned ELEM_W      = $clog2(VEC_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [VEC_W-1:0]       wr_vec,
    input  logic [ELEM_W-1:0]      wr_elem,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_last,
    input  logic                   rd_req_valid,
    output logic                   rd_req_ready,
    input  logic [VEC_W-1:0]       rd_req_vec,
    output logic                   rd_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [ELEM_W-1:0]      out_elem,
    output logic                   out_last,
    output logic [NUM_VECTORS-1:0] vec_loaded
);

    localparam int unsigned DEPTH  = NUM_VECTORS * VEC_LEN;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W  = $clog2(VEC_LEN + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state;
    logic [VEC_W-1:0]        cur_vec;
    logic                    cur_oor;
    logic [PTR_W-1:0]        ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_fire;
    logic                    wr_in_range;
    logic [ADDR_W-1:0]       wr_addr;
    logic                    req_fire;
    logic                    req_oor;
    logic                    req_loaded;
    logic                    adv;
    logic [VEC_W-1:0]        fetch_vec;
    logic [PTR_W-1:0]        fetch_ptr;
    logic                    fetch_ok;
    logic [ADDR_W-1:0]       fetch_addr;
    logic [DATA_WIDTH-1:0]   fetch_data;

    // Handshake decode, address generation and array read port.
    always_comb begin
        // rst_n gate keeps a write from landing on the first reset edge,
        // while wr_ready still shows its pre-reset value.
        wr_fire     = wr_valid && wr_ready && rst_n;
        wr_in_range = (32'(wr_vec) < NUM_VECTORS) && (32'(wr_elem) < VEC_LEN);
        wr_addr     = '0;
        if (wr_in_range) begin
            wr_addr = ADDR_W'(32'(wr_vec) * VEC_LEN + 32'(wr_elem));
        end

        req_fire   = (state == IDLE) && rd_req_valid && rd_req_ready;
        req_oor    = 32'(rd_req_vec) >= NUM_VECTORS;
        req_loaded = !req_oor && vec_loaded[rd_req_vec];
        adv        = !out_valid || out_ready;

        // In IDLE the read port looks at element 0 of the requested vector so
        // the first element is presented right after the accepting edge.
        fetch_vec  = (state == IDLE) ? rd_req_vec : cur_vec;
        fetch_ptr  = (state == IDLE) ? '0 : ptr;
        fetch_ok   = ((state == IDLE) ? !req_oor : !cur_oor) && (32'(fetch_ptr) < VEC_LEN);
        fetch_addr = '0;
        if (fetch_ok) begin
            fetch_addr = ADDR_W'(32'(fetch_vec) * VEC_LEN + 32'(fetch_ptr));
        end
        // Out-of-range vectors stream zeros.
        fetch_data = fetch_ok ? mem[fetch_addr] : '0;
    end

    // Storage array; not reset. Read sees the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-side status and read FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            cur_vec      <= '0;
            cur_oor      <= 1'b0;
            wr_ready     <= 1'b0;
            rd_req_ready <= 1'b0;
            rd_err       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_elem     <= '0;
            out_last     <= 1'b0;
            vec_loaded   <= '0;
        end else begin
            wr_ready <= 1'b1;
            rd_err   <= 1'b0;

            // A partial rewrite invalidates the vector until its last element lands.
            if (wr_fire && wr_in_range) begin
                vec_loaded[wr_vec] <= wr_last;
            end

            case (state)
                IDLE: begin
                    rd_req_ready <= 1'b1;
                    if (req_fire) begin
                        rd_err       <= !req_loaded;
                        cur_vec      <= rd_req_vec;
                        cur_oor      <= req_oor;
                        rd_req_ready <= 1'b0;
                        state        <= STREAM;
                        // Element 0 is issued on the accepting edge; ptr continues from 1.
                        out_data     <= fetch_data;
                        out_elem     <= '0;
                        out_last     <= 1'b0;
                        out_valid    <= 1'b1;
                        ptr          <= PTR_W'(1);
                    end
                end
                STREAM: begin
                    if (adv) begin
                        if (32'(ptr) < VEC_LEN) begin
                            out_data  <= fetch_data;
                            out_elem  <= ELEM_W'(ptr);
                            out_last  <= (32'(ptr) == VEC_LEN - 1);
                            out_valid <= 1'b1;
                            ptr       <= ptr + PTR_W'(1);
                        end else begin
                            // All elements issued, so adv here is the last element's handshake.
                            out_valid    <= 1'b0;
                            rd_req_ready <= 1'b1;
                            ptr          <= '0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_stream_memory.sv
// Self-checking bench for vector_stream_memory (NUM_VECTORS=3 so that
// out-of-range vector indices can be exercised): reset values, a table of
// per-cycle vectors for load-and-stream, directed multi-cycle corner cases,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_vector_stream_memory;

    localparam int unsigned DW = 8;
    localparam int unsigned VL = 8;
    localparam int unsigned NV = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [1:0]     wr_vec = '0;
    logic [2:0]     wr_elem = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_last = 1'b0;
    logic           rd_req_valid = 1'b0;
    logic           rd_req_ready;
    logic [1:0]     rd_req_vec = '0;
    logic           rd_err;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic [2:0]     out_elem;
    logic           out_last;
    logic [NV-1:0]  vec_loaded;

    always #5 clk = ~clk;

    vector_stream_memory #(
        .DATA_WIDTH (DW),
        .VEC_LEN    (VL),
        .NUM_VECTORS(NV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_vec      (wr_vec),
        .wr_elem     (wr_elem),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_req_vec  (rd_req_vec),
        .rd_err      (rd_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_elem    (out_elem),
        .out_last    (out_last),
        .vec_loaded  (vec_loaded)
    );

    typedef struct {
        logic       wv;
        logic [1:0] wvec;
        logic [2:0] welem;
        logic [7:0] wdata;
        logic       wlast;
        logic       rv;
        logic [1:0] rvec;
        logic       ordy;
        logic       ev;
        logic [7:0] edata;
        logic [2:0] eelem;
        logic       elast;
        logic       eerr;
        logic [2:0] eloaded;
        logic       erdy;
    } row_t;

    row_t tbl [17];

    int n_checks = 0;
    int n_pass   = 0;

    // Stream capture
    logic [7:0] got [8];
    int         got_n;
    logic       got_err;
    logic       got_err2;
    logic [7:0] or_data;

    // Backpressure / back-to-back bookkeeping
    int         cnt;
    logic       stalled;
    logic [7:0] prev_data;
    logic [2:0] prev_elem;
    logic       prev_last;
    logic       rdy;
    int         t_last;
    int         gap;

    // Reference model state
    logic [7:0] m_mem [3][8];
    logic [2:0] m_loaded;
    logic       m_stream;
    logic [1:0] m_vec;
    int         m_idx;
    logic [7:0] m_hold;
    logic       m_err;
    logic       new_elem;
    logic       p_wv, p_wl, p_rv, p_ordy;
    logic [1:0] p_wvec, p_rvec;
    logic [2:0] p_welem;
    logic [7:0] p_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic [1:0] v, input logic [2:0] e, input logic [7:0] d,
                              input logic l);
        wr_valid = 1'b1;
        wr_vec   = v;
        wr_elem  = e;
        wr_data  = d;
        wr_last  = l;
        cyc();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Request vector v with out_ready=1 and capture the stream until out_valid drops.
    task automatic run_stream(input logic [1:0] v);
        rd_req_valid = 1'b1;
        rd_req_vec   = v;
        out_ready    = 1'b1;
        cyc();
        rd_req_valid = 1'b0;
        got_err  = rd_err;
        got_err2 = 1'b1;
        got_n    = 0;
        or_data  = '0;
        for (int i = 0; i < 20 && out_valid; i++) begin
            if (i == 1) got_err2 = rd_err;
            if (got_n < 8) got[got_n] = out_data;
            or_data = or_data | out_data;
            got_n++;
            cyc();
        end
    endtask

    function automatic row_t mk(logic wv, logic [1:0] wvec, logic [2:0] we, logic [7:0] wd,
                                logic wl, logic rv, logic [1:0] rvec, logic ordy,
                                logic ev, logic [7:0] ed, logic [2:0] ee, logic el,
                                logic eerr, logic [2:0] eld, logic erdy);
        row_t r;
        r.wv = wv; r.wvec = wvec; r.welem = we; r.wdata = wd; r.wlast = wl;
        r.rv = rv; r.rvec = rvec; r.ordy = ordy;
        r.ev = ev; r.edata = ed; r.eelem = ee; r.elast = el; r.eerr = eerr;
        r.eloaded = eld; r.erdy = erdy;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Load vector 2 with 0x10..0x17, then stream it with out_ready held high.
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1'b1, 2'd2, 3'(k), 8'(32'h10 + k), (k == 7), 1'b0, 2'd0, 1'b1,
                        1'b0, 8'h00, 3'd0, 1'b0, 1'b0, (k == 7) ? 3'b100 : 3'b000, 1'b1);
        tbl[8] = mk(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1,
                    1'b1, 8'h10, 3'd0, 1'b0, 1'b0, 3'b100, 1'b0);
        for (int k = 1; k < 8; k++)
            tbl[8 + k] = mk(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1,
                            1'b1, 8'(32'h10 + k), 3'(k), (k == 7), 1'b0, 3'b100, 1'b0);
        tbl[16] = mk(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1,
                     1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'b100, 1'b1);

        // Reset state
        cyc(); cyc();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_elem", 32'(out_elem), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_rd_err", 32'(rd_err), 32'(0));
        check("rst_vec_loaded", 32'(vec_loaded), 32'(0));
        check("rst_wr_ready", 32'(wr_ready), 32'(0));
        check("rst_rd_req_ready", 32'(rd_req_ready), 32'(0));
        rst_n = 1'b1;
        cyc(); cyc();
        check("post_rst_wr_ready", 32'(wr_ready), 32'(1));
        check("post_rst_rd_req_ready", 32'(rd_req_ready), 32'(1));

        // Table-driven load and stream
        for (int r = 0; r < 17; r++) begin
            wr_valid = tbl[r].wv; wr_vec = tbl[r].wvec; wr_elem = tbl[r].welem;
            wr_data = tbl[r].wdata; wr_last = tbl[r].wlast;
            rd_req_valid = tbl[r].rv; rd_req_vec = tbl[r].rvec; out_ready = tbl[r].ordy;
            cyc();
            check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
            check($sformatf("tbl%0d_err", r), 32'(rd_err), 32'(tbl[r].eerr));
            check($sformatf("tbl%0d_loaded", r), 32'(vec_loaded), 32'(tbl[r].eloaded));
            check($sformatf("tbl%0d_rd_req_ready", r), 32'(rd_req_ready), 32'(tbl[r].erdy));
            if (tbl[r].ev) begin
                check($sformatf("tbl%0d_data", r), 32'(out_data), 32'(tbl[r].edata));
                check($sformatf("tbl%0d_elem", r), 32'(out_elem), 32'(tbl[r].eelem));
                check($sformatf("tbl%0d_last", r), 32'(out_last), 32'(tbl[r].elast));
            end
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0;

        // Backpressure: out_ready pattern 1,0,0,1 repeating
        rd_req_valid = 1'b1; rd_req_vec = 2'd2; out_ready = 1'b0;
        cyc();
        rd_req_valid = 1'b0;
        cnt = 0; stalled = 1'b0;
        prev_data = '0; prev_elem = '0; prev_last = 1'b0;
        for (int i = 0; i < 64 && cnt < 8; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'(1));
            check($sformatf("bp%0d_elem", i), 32'(out_elem), 32'(cnt));
            check($sformatf("bp%0d_data", i), 32'(out_data), 32'(32'h10 + cnt));
            check($sformatf("bp%0d_last", i), 32'(out_last), 32'(cnt == 7));
            if (stalled)
                check($sformatf("bp%0d_hold", i), {21'd0, prev_last, prev_elem, prev_data},
                      {21'd0, out_last, out_elem, out_data});
            rdy = (i % 4 == 0) || (i % 4 == 3);
            out_ready = rdy;
            prev_data = out_data; prev_elem = out_elem; prev_last = out_last;
            stalled = !rdy;
            if (rdy) cnt++;
            cyc();
        end
        check("bp_count", 32'(cnt), 32'(8));
        check("bp_end_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b1;

        // Unloaded and out-of-range requests after reset
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc(); cyc();
        run_stream(2'd1);
        check("unl_err", 32'(got_err), 32'(1));
        check("unl_err_pulse", 32'(got_err2), 32'(0));
        check("unl_len", 32'(got_n), 32'(8));
        check("unl_idle", 32'(rd_req_ready), 32'(1));
        run_stream(2'd3);
        check("oor_err", 32'(got_err), 32'(1));
        check("oor_len", 32'(got_n), 32'(8));
        check("oor_zeros", 32'(or_data), 32'(0));

        // Read/write collision on vector 0
        for (int k = 0; k < 8; k++) write_elem(2'd0, 3'(k), 8'(32'hA0 + k), (k == 7));
        check("col_loaded", 32'(vec_loaded), 32'(3'b001));
        rd_req_valid = 1'b1; rd_req_vec = 2'd0; out_ready = 1'b1;
        cyc();
        rd_req_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        check("col_elem4", 32'(out_elem), 32'(4));
        wr_valid = 1'b1; wr_vec = 2'd0; wr_elem = 3'd5; wr_data = 8'h55; wr_last = 1'b1;
        cyc();
        wr_valid = 1'b0; wr_last = 1'b0;
        check("col_elem5", 32'(out_elem), 32'(5));
        check("col_old_data", 32'(out_data), 32'(8'hA5));
        cyc(); cyc(); cyc();
        check("col_idle", 32'(rd_req_ready), 32'(1));
        run_stream(2'd0);
        check("col_new_data", 32'(got[5]), 32'(8'h55));
        check("col_neighbour", 32'(got[4]), 32'(8'hA4));
        check("col_err", 32'(got_err), 32'(0));
        write_elem(2'd0, 3'd0, 8'hA0, 1'b0);
        check("rewrite_clears_loaded", 32'(vec_loaded[0]), 32'(0));

        // Reset mid-stream
        rd_req_valid = 1'b1; rd_req_vec = 2'd2; out_ready = 1'b1;
        cyc();
        rd_req_valid = 1'b0;
        cyc(); cyc(); cyc();
        check("mid_elem3", 32'(out_elem), 32'(3));
        rst_n = 1'b0;
        cyc();
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_loaded", 32'(vec_loaded), 32'(0));
        check("mid_rst_wr_ready", 32'(wr_ready), 32'(0));
        check("mid_rst_rd_req_ready", 32'(rd_req_ready), 32'(0));
        rst_n = 1'b1;
        cyc(); cyc();
        run_stream(2'd2);
        check("mid_len", 32'(got_n), 32'(8));
        check("mid_err_unloaded", 32'(got_err), 32'(1));
        for (int k = 0; k < 8; k++)
            check($sformatf("mid_data%0d", k), 32'(got[k]), 32'(32'h10 + k));

        // Back-to-back requests: 1-cycle bubble
        rd_req_valid = 1'b1; rd_req_vec = 2'd2; out_ready = 1'b1;
        t_last = -1; gap = -1;
        for (int t = 0; t < 40 && gap < 0; t++) begin
            cyc();
            if (out_valid && out_elem == 3'd0 && t_last >= 0) gap = t - t_last;
            if (out_valid && out_last) t_last = t;
        end
        rd_req_valid = 1'b0;
        check("b2b_gap", 32'(gap), 32'(2));
        for (int t = 0; t < 20 && !rd_req_ready; t++) cyc();
        check("b2b_drained", 32'(rd_req_ready), 32'(1));

        // Preload all vectors with random data for the model
        for (int v = 0; v < 3; v++)
            for (int e = 0; e < 8; e++) begin
                m_mem[v][e] = 8'($urandom);
                write_elem(2'(v), 3'(e), m_mem[v][e], (e == 7));
            end
        m_loaded = 3'b111;
        check("pre_loaded", 32'(vec_loaded), 32'(m_loaded));

        // Randomized traffic against the reference model
        m_stream = 1'b0; m_vec = '0; m_idx = 0; m_hold = '0; m_err = 1'b0;
        for (int c = 0; c < 800; c++) begin
            wr_valid     = ($urandom % 3) == 0;
            wr_vec       = 2'($urandom % 4);
            wr_elem      = 3'($urandom % 8);
            wr_data      = 8'($urandom);
            wr_last      = ($urandom % 4) == 0;
            rd_req_valid = ($urandom % 4) == 0;
            rd_req_vec   = 2'($urandom % 4);
            out_ready    = ($urandom % 3) != 0;
            p_wv = wr_valid; p_wvec = wr_vec; p_welem = wr_elem; p_wd = wr_data;
            p_wl = wr_last; p_rv = rd_req_valid; p_rvec = rd_req_vec; p_ordy = out_ready;
            cyc();
            // Effects of the edge just taken, computed from the pre-edge model state
            new_elem = 1'b0;
            m_err    = 1'b0;
            if (m_stream) begin
                if (p_ordy) begin
                    if (m_idx == 7) m_stream = 1'b0;
                    else begin m_idx++; new_elem = 1'b1; end
                end
            end else if (p_rv) begin
                m_err    = (32'(p_rvec) >= NV) ? 1'b1 : !m_loaded[p_rvec];
                m_stream = 1'b1;
                m_vec    = p_rvec;
                m_idx    = 0;
                new_elem = 1'b1;
            end
            if (new_elem) m_hold = (32'(m_vec) >= NV) ? 8'h00 : m_mem[m_vec][m_idx];
            if (p_wv && 32'(p_wvec) < NV) begin
                m_mem[p_wvec][p_welem] = p_wd;
                m_loaded[p_wvec]       = p_wl;
            end
            check($sformatf("rnd%0d_wr_ready", c), 32'(wr_ready), 32'(1));
            check($sformatf("rnd%0d_rd_req_ready", c), 32'(rd_req_ready), 32'(!m_stream));
            check($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(m_stream));
            check($sformatf("rnd%0d_err", c), 32'(rd_err), 32'(m_err));
            check($sformatf("rnd%0d_loaded", c), 32'(vec_loaded), 32'(m_loaded));
            if (m_stream) begin
                check($sformatf("rnd%0d_elem", c), 32'(out_elem), 32'(m_idx));
                check($sformatf("rnd%0d_data", c), 32'(out_data), 32'(m_hold));
                check($sformatf("rnd%0d_last", c), 32'(out_last), 32'(m_idx == 7));
            end
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
